mux4_rr_sched: RTL and testbench

Round-robin scheduler that shares one `mux_4_1` datapath between four requesters. It arbitrates four level requests and drives the mux selects `s1`/`s0`. It also registers the mux output `y` together with a valid flag and a source tag. It sits directly in front of `mux_4_1`: its `s1`/`s0` outputs connect to the mux select ports, and the mux output `y` returns on `y_in`.

---
 rtl/mux4_sched_pkg.sv | 16 +
 rtl/rr_pick4.sv | 47 ++++
 rtl/mux4_rr_sched.sv | 150 +++++++++++++++
 tb/tb_mux4_rr_sched.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/mux4_sched_pkg.sv
// Shared types and helpers for the round-robin scheduler in front of mux_4_1.
package mux4_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_t;

    localparam int IDX_W  = 2;
    localparam int HCNT_W = 8;

    function automatic logic [3:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request scanning from ptr with wrap,
// optionally excluding one index.
module rr_pick4
    import mux4_sched_pkg::*;
(
    input  logic [3:0]       req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             excl_en,
    input  logic [IDX_W-1:0] excl_idx,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [3:0]       cand_s;
    logic [3:0]       rot_s;
    logic [IDX_W-1:0] off_s;

    assign cand_s = req & ~(excl_en ? idx_to_onehot(excl_idx) : 4'b0000);

    // Rotate candidates so that bit 0 is the requester at ptr.
    always_comb begin
        rot_s = cand_s;
        case (ptr)
            2'd0:    rot_s = cand_s;
            2'd1:    rot_s = {cand_s[0],   cand_s[3:1]};
            2'd2:    rot_s = {cand_s[1:0], cand_s[3:2]};
            2'd3:    rot_s = {cand_s[2:0], cand_s[3]};
            default: rot_s = cand_s;
        endcase
    end

    // Priority encode the rotated vector into an offset from ptr.
    always_comb begin
        found = 1'b0;
        off_s = 2'd0;
        casez (rot_s)
            4'b???1: begin found = 1'b1; off_s = 2'd0; end
            4'b??10: begin found = 1'b1; off_s = 2'd1; end
            4'b?100: begin found = 1'b1; off_s = 2'd2; end
            4'b1000: begin found = 1'b1; off_s = 2'd3; end
            default: begin found = 1'b0; off_s = 2'd0; end
        endcase
    end

    assign idx = ptr + off_s;

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler driving the mux_4_1 selects, with hold limit and a
// registered, source-tagged sample of the mux output.
module mux4_rr_sched
    import mux4_sched_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic             y_in,
    output logic [3:0]       gnt,
    output logic             s1,
    output logic             s0,
    output logic             busy,
    output logic             y_q,
    output logic             y_vld,
    output logic [IDX_W-1:0] y_src
);

    localparam logic [HCNT_W-1:0] HOLD_LIM = HCNT_W'(HOLD_MAX);
    localparam logic [HCNT_W-1:0] HCNT_ONE = HCNT_W'(1);

    sched_state_t      state_r, state_s;
    logic [IDX_W-1:0]  ptr_r, ptr_s;
    logic [HCNT_W-1:0] hcnt_r, hcnt_s;
    logic [3:0]        gnt_r, gnt_s;
    logic [IDX_W-1:0]  sel_r, sel_s;
    logic              busy_r, busy_s;
    logic              y_q_r, y_vld_r;
    logic [IDX_W-1:0]  y_src_r;

    logic [IDX_W-1:0]  pick_ptr_s;
    logic              pick_excl_s;
    logic              pick_found_s;
    logic [IDX_W-1:0]  pick_idx_s;

    // While granting, the scan starts after the holder and skips it; a released
    // holder has its request low anyway, so one picker covers both cases.
    assign pick_excl_s = (state_r == GRANT);
    assign pick_ptr_s  = pick_excl_s ? (sel_r + 2'd1) : ptr_r;

    rr_pick4 u_pick (
        .req      (req),
        .ptr      (pick_ptr_s),
        .excl_en  (pick_excl_s),
        .excl_idx (sel_r),
        .found    (pick_found_s),
        .idx      (pick_idx_s)
    );

    // Next-state logic for the grant FSM, rotation pointer and hold counter.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        hcnt_s  = hcnt_r;
        gnt_s   = gnt_r;
        sel_s   = sel_r;
        busy_s  = busy_r;
        case (state_r)
            IDLE: begin
                if (pick_found_s) begin
                    state_s = GRANT;
                    gnt_s   = idx_to_onehot(pick_idx_s);
                    sel_s   = pick_idx_s;
                    busy_s  = 1'b1;
                    hcnt_s  = HCNT_ONE;
                end else begin
                    gnt_s   = 4'b0000;
                    busy_s  = 1'b0;
                end
            end
            GRANT: begin
                if (!req[sel_r]) begin
                    ptr_s = sel_r + 2'd1;
                    if (pick_found_s) begin
                        gnt_s  = idx_to_onehot(pick_idx_s);
                        sel_s  = pick_idx_s;
                        hcnt_s = HCNT_ONE;
                    end else begin
                        state_s = IDLE;
                        gnt_s   = 4'b0000;
                        busy_s  = 1'b0;
                        hcnt_s  = '0;
                    end
                end else if (hcnt_r == HOLD_LIM) begin
                    if (pick_found_s) begin
                        ptr_s  = sel_r + 2'd1;
                        gnt_s  = idx_to_onehot(pick_idx_s);
                        sel_s  = pick_idx_s;
                        hcnt_s = HCNT_ONE;
                    end else begin
                        hcnt_s = HCNT_ONE;
                    end
                end else begin
                    hcnt_s = hcnt_r + HCNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                gnt_s   = 4'b0000;
                busy_s  = 1'b0;
                hcnt_s  = '0;
            end
        endcase
    end

    // FSM and grant output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            ptr_r   <= 2'd0;
            hcnt_r  <= '0;
            gnt_r   <= 4'b0000;
            sel_r   <= 2'd0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            hcnt_r  <= hcnt_s;
            gnt_r   <= gnt_s;
            sel_r   <= sel_s;
            busy_r  <= busy_s;
        end
    end

    // Sample the mux output, tagged with the select that was driving it.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q_r   <= 1'b0;
            y_vld_r <= 1'b0;
            y_src_r <= 2'd0;
        end else if (busy_r) begin
            y_q_r   <= y_in;
            y_vld_r <= 1'b1;
            y_src_r <= sel_r;
        end else begin
            y_vld_r <= 1'b0;
        end
    end

    assign gnt   = gnt_r;
    assign s1    = sel_r[1];
    assign s0    = sel_r[0];
    assign busy  = busy_r;
    assign y_q   = y_q_r;
    assign y_vld = y_vld_r;
    assign y_src = y_src_r;

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Scoreboard bench for mux4_rr_sched (HOLD_MAX=3) with a behavioural mux_4_1
// whose inputs are i0=1, i1=0, i2=1, i3=0.
module tb_mux4_rr_sched;

    typedef struct {
        int         id;
        logic [10:0] v;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       y_in;
    logic [3:0] gnt;
    logic       s1;
    logic       s0;
    logic       busy;
    logic       y_q;
    logic       y_vld;
    logic [1:0] y_src;
    logic [3:0] mux_in;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;
    int   step_id;

    mux4_rr_sched #(.HOLD_MAX(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .y_in  (y_in),
        .gnt   (gnt),
        .s1    (s1),
        .s0    (s0),
        .busy  (busy),
        .y_q   (y_q),
        .y_vld (y_vld),
        .y_src (y_src)
    );

    assign y_in = mux_in[{s1, s0}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] ex(input logic [3:0] g, input logic [1:0] sel,
                                       input logic b, input logic yq,
                                       input logic yv, input logic [1:0] ys);
        return {g, sel, b, yq, yv, ys};
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic r, input logic [3:0] rq, input logic [10:0] e);
        @(negedge clk);
        #1;
        rst = r;
        req = rq;
        step_id = step_id + 1;
        exp_q.push_back('{id: step_id, v: e});
    endtask

    // Monitor: one queued expectation is due at each falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [10:0] act;
            e   = exp_q.pop_front();
            act = {gnt, s1, s0, busy, y_q, y_vld, y_src};
            n_checks = n_checks + 1;
            if (act !== e.v) begin
                n_fail = n_fail + 1;
                $display("FAIL snapshot step %0d: got gnt=%b sel=%b busy=%b y_q=%b y_vld=%b y_src=%b, expected gnt=%b sel=%b busy=%b y_q=%b y_vld=%b y_src=%b",
                         e.id, act[10:7], act[6:5], act[4], act[3], act[2], act[1:0],
                         e.v[10:7], e.v[6:5], e.v[4], e.v[3], e.v[2], e.v[1:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        step_id  = 0;
        rst      = 1'b1;
        req      = 4'b1111;
        mux_in   = 4'b0101;

        // Reset with all requests asserted.
        step(1'b1, 4'b1111, ex(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00));
        step(1'b1, 4'b1111, ex(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00));
        step(1'b0, 4'b1111, ex(4'b0001, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00));

        // Round-robin cycling with release-and-reassert; samples trail selects.
        step(1'b0, 4'b1110, ex(4'b0010, 2'b01, 1'b1, 1'b1, 1'b1, 2'b00));
        step(1'b0, 4'b1101, ex(4'b0100, 2'b10, 1'b1, 1'b0, 1'b1, 2'b01));
        step(1'b0, 4'b1011, ex(4'b1000, 2'b11, 1'b1, 1'b1, 1'b1, 2'b10));
        step(1'b0, 4'b0111, ex(4'b0001, 2'b00, 1'b1, 1'b0, 1'b1, 2'b11));
        step(1'b0, 4'b0000, ex(4'b0000, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00));
        step(1'b0, 4'b0000, ex(4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00));

        // Forced rotation between 0 and 1 every three cycles.
        step(1'b1, 4'b0011, ex(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00));
        step(1'b0, 4'b0011, ex(4'b0001, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00));
        step(1'b0, 4'b0011, ex(4'b0001, 2'b00, 1'b1, 1'b1, 1'b1, 2'b00));
        step(1'b0, 4'b0011, ex(4'b0001, 2'b00, 1'b1, 1'b1, 1'b1, 2'b00));
        step(1'b0, 4'b0011, ex(4'b0010, 2'b01, 1'b1, 1'b1, 1'b1, 2'b00));
        step(1'b0, 4'b0011, ex(4'b0010, 2'b01, 1'b1, 1'b0, 1'b1, 2'b01));
        step(1'b0, 4'b0011, ex(4'b0010, 2'b01, 1'b1, 1'b0, 1'b1, 2'b01));
        step(1'b0, 4'b0011, ex(4'b0001, 2'b00, 1'b1, 1'b0, 1'b1, 2'b01));
        step(1'b0, 4'b0011, ex(4'b0001, 2'b00, 1'b1, 1'b1, 1'b1, 2'b00));
        step(1'b0, 4'b0011, ex(4'b0001, 2'b00, 1'b1, 1'b1, 1'b1, 2'b00));
        step(1'b0, 4'b0011, ex(4'b0010, 2'b01, 1'b1, 1'b1, 1'b1, 2'b00));

        // Lone holder: index 2 keeps its grant across several hold limits.
        step(1'b0, 4'b0100, ex(4'b0100, 2'b10, 1'b1, 1'b0, 1'b1, 2'b01));
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 4'b0100, ex(4'b0100, 2'b10, 1'b1, 1'b1, 1'b1, 2'b10));
        end

        // Reset mid-grant (hcnt=2), then regrant and a fresh hold count.
        step(1'b1, 4'b0100, ex(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00));
        step(1'b0, 4'b0100, ex(4'b0100, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00));
        step(1'b0, 4'b0100, ex(4'b0100, 2'b10, 1'b1, 1'b1, 1'b1, 2'b10));
        step(1'b0, 4'b0101, ex(4'b0100, 2'b10, 1'b1, 1'b1, 1'b1, 2'b10));
        step(1'b0, 4'b0101, ex(4'b0001, 2'b00, 1'b1, 1'b1, 1'b1, 2'b10));
        step(1'b0, 4'b0000, ex(4'b0000, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00));
        step(1'b0, 4'b0000, ex(4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00));

        // Sample tagging with single requests stepping 0 -> 3.
        step(1'b0, 4'b0001, ex(4'b0001, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00));
        step(1'b0, 4'b0010, ex(4'b0010, 2'b01, 1'b1, 1'b1, 1'b1, 2'b00));
        step(1'b0, 4'b0100, ex(4'b0100, 2'b10, 1'b1, 1'b0, 1'b1, 2'b01));
        step(1'b0, 4'b1000, ex(4'b1000, 2'b11, 1'b1, 1'b1, 1'b1, 2'b10));
        step(1'b0, 4'b0000, ex(4'b0000, 2'b11, 1'b0, 1'b0, 1'b1, 2'b11));
        step(1'b0, 4'b0000, ex(4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 2'b11));

        @(negedge clk);
        #1;
        n_checks = n_checks + 1;
        if (exp_q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
